ccip_rd_arbiter: RTL and testbench

CCIP_RD_ARBITER -- requirements
Module: ccip_rd_arbiter

---
 rtl/ccip_rd_arbiter.sv | 152 +++++++++++++++
 tb/tb_ccip_rd_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_rd_arbiter.sv
// Round-robin CCI-P c0 read arbiter with credit tracking and tag-based response routing.
// Optional perf counters (perf_reads, perf_stalls) are enabled by CCIP_RD_ARBITER_PERF_EN.
module ccip_rd_arbiter #(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*42-1:0]   req_addr,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  c0_alm_full,
  output logic                  c0_tx_valid,
  output logic [41:0]           c0_tx_addr,
  output logic [15:0]           c0_tx_mdata,
  input  logic                  c0_rsp_valid,
  input  logic [15:0]           c0_rsp_mdata,
  input  logic [511:0]          c0_rsp_data,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [511:0]          rsp_data,
  input  logic                  drain,
  output logic                  idle,
  output logic                  err_unexpected
`ifdef CCIP_RD_ARBITER_PERF_EN
  ,
  output logic [31:0]           perf_reads,
  output logic [31:0]           perf_stalls
`endif
);

  localparam int unsigned IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  MAX_CNT = 8'(MAX_OUTSTANDING);

  logic [IW-1:0]    r_last_grant;
  logic [7:0]       r_count;
  logic [12:0]      r_seq;
  logic             r_tx_valid;
  logic [41:0]      r_tx_addr;
  logic [15:0]      r_tx_mdata;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [511:0]     r_rsp_data;
  logic             r_idle;
  logic             r_err;

  logic             w_gnt_found;
  logic [IW-1:0]    w_gnt_idx;
  logic [IW-1:0]    w_scan;
  logic             w_grant;
  logic [41:0]      w_gnt_addr;
  logic [2:0]       w_tag;
  logic             w_tag_ok;
  logic             w_accept;
  logic [7:0]       w_next_count;
  logic             w_unused;

  // Scan starts one past the last winner and wraps, so the previous winner is checked last.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_scan = IW'((32'(r_last_grant) + k) % N_REQ);
      if (!w_gnt_found && req_valid[w_scan]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan;
      end
    end
  end

  assign w_grant = !reset && w_gnt_found && !c0_alm_full && !drain && (r_count < MAX_CNT);

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    w_gnt_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IW'(i) == w_gnt_idx) w_gnt_addr = req_addr[i*42 +: 42];
    end
  end

  assign w_tag    = c0_rsp_mdata[2:0];
  assign w_tag_ok = 32'(w_tag) < N_REQ;
  assign w_accept = c0_rsp_valid && (r_count != '0) && w_tag_ok;
  assign w_unused = ^c0_rsp_mdata[15:3];

  always_comb begin
    w_next_count = r_count;
    if (w_grant && !w_accept)      w_next_count = r_count + 8'd1;
    else if (!w_grant && w_accept) w_next_count = r_count - 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= IW'(N_REQ - 1);
      r_count      <= '0;
      r_seq        <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_addr    <= '0;
      r_tx_mdata   <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_idle       <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      r_tx_valid <= w_grant;
      if (w_grant) begin
        r_tx_addr    <= w_gnt_addr;
        r_tx_mdata   <= {r_seq, 3'(w_gnt_idx)};
        r_seq        <= r_seq + 13'd1;
        r_last_grant <= w_gnt_idx;
      end
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_rsp_valid[w_tag[IW-1:0]] <= 1'b1;
        r_rsp_data                 <= c0_rsp_data;
      end
      if (c0_rsp_valid && !w_accept) r_err <= 1'b1;
      r_count <= w_next_count;
      r_idle  <= (w_next_count == '0);
    end
  end

  assign c0_tx_valid    = r_tx_valid;
  assign c0_tx_addr     = r_tx_addr;
  assign c0_tx_mdata    = r_tx_mdata;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign idle           = r_idle;
  assign err_unexpected = r_err;

`ifdef CCIP_RD_ARBITER_PERF_EN
  logic [31:0] r_perf_reads;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_reads  <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_grant && (r_perf_reads != '1)) r_perf_reads <= r_perf_reads + 32'd1;
      if ((|req_valid) && !w_grant && (r_perf_stalls != '1)) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_reads  = r_perf_reads;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Scoreboard bench for ccip_rd_arbiter: a driver predicts grants/responses into queues,
// an independent monitor pops and compares whenever the DUT presents a transfer.
module tb_ccip_rd_arbiter;
  localparam int N   = 4;
  localparam int MAX = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*42-1:0] req_addr;
  logic [N-1:0]   req_ready;
  logic           c0_alm_full;
  logic           c0_tx_valid;
  logic [41:0]    c0_tx_addr;
  logic [15:0]    c0_tx_mdata;
  logic           c0_rsp_valid;
  logic [15:0]    c0_rsp_mdata;
  logic [511:0]   c0_rsp_data;
  logic [N-1:0]   rsp_valid;
  logic [511:0]   rsp_data;
  logic           drain;
  logic           idle;
  logic           err_unexpected;
`ifdef CCIP_RD_ARBITER_PERF_EN
  logic [31:0]    perf_reads;
  logic [31:0]    perf_stalls;
`endif

  always #5 clk = ~clk;

  ccip_rd_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .c0_alm_full(c0_alm_full), .c0_tx_valid(c0_tx_valid),
    .c0_tx_addr(c0_tx_addr), .c0_tx_mdata(c0_tx_mdata), .c0_rsp_valid(c0_rsp_valid),
    .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .drain(drain), .idle(idle), .err_unexpected(err_unexpected)
`ifdef CCIP_RD_ARBITER_PERF_EN
    , .perf_reads(perf_reads), .perf_stalls(perf_stalls)
`endif
  );

  typedef struct { logic [41:0] addr; logic [15:0] mdata; } tx_t;
  typedef struct { logic [N-1:0] vld; logic [511:0] data; } rsp_t;

  tx_t         tx_q[$];
  rsp_t        rsp_q[$];
  logic [15:0] inflight[$];
  logic [15:0] obs_mdata[$];
  int          obs_rsp;

  int   m_count, m_last, m_seq;
  logic m_err;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic use_fix  = 1'b0;

  tx_t  et;
  rsp_t er;
  logic [15:0] saved[$];
  logic [15:0] fair_exp [6] = '{16'h0000, 16'h0009, 16'h0012, 16'h001B, 16'h0020, 16'h0029};

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] r512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: compares every registered transfer against the scoreboard queues.
  always @(posedge clk) begin
    #1;
    if (c0_tx_valid === 1'b1) begin
      obs_mdata.push_back(c0_tx_mdata);
      if (tx_q.size() == 0) chk("tx_spurious", 1, 0);
      else begin
        et = tx_q.pop_front();
        chk("tx_addr", c0_tx_addr, et.addr);
        chk("tx_mdata", c0_tx_mdata, et.mdata);
      end
    end else if (tx_q.size() != 0) begin
      chk("tx_missing", 0, 1);
      void'(tx_q.pop_front());
    end
    if (rsp_valid !== '0) begin
      obs_rsp++;
      if (rsp_q.size() == 0) chk("rsp_spurious", rsp_valid, 0);
      else begin
        er = rsp_q.pop_front();
        chk("rsp_valid", rsp_valid, er.vld);
        chk("rsp_data", rsp_data, er.data);
      end
    end else if (rsp_q.size() != 0) begin
      chk("rsp_missing", 0, 1);
      void'(rsp_q.pop_front());
    end
    chk("idle", idle, (m_count == 0));
    chk("err_unexpected", err_unexpected, m_err);
  end

  // rmode: 0 no response, 1 oldest in-flight tag, 2 explicit tag, 3 random in-flight tag
  task automatic step(input logic [N-1:0] v, input logic alm, input logic dr,
                      input int rmode, input logic [15:0] rtag_in);
    logic rv, ok;
    logic [15:0] rtag;
    logic [511:0] rd;
    logic [63:0] a;
    logic [N-1:0] exp_rdy;
    int g, pick;
    @(negedge clk);
    rv = 1'b0; rtag = rtag_in; rd = use_fix ? 512'hAB : r512();
    if ((rmode == 1 || rmode == 3) && inflight.size() > 0) begin
      pick = (rmode == 1) ? 0 : $urandom_range(inflight.size() - 1, 0);
      rtag = inflight[pick];
      inflight.delete(pick);
      rv = 1'b1;
    end else if (rmode == 2) rv = 1'b1;
    for (int i = 0; i < N; i++) begin
      a = {$urandom, $urandom};
      req_addr[i*42 +: 42] = a[41:0];
    end
    if (use_fix) req_addr[41:0] = 42'h100;
    req_valid = v; c0_alm_full = alm; drain = dr;
    c0_rsp_valid = rv; c0_rsp_mdata = rtag; c0_rsp_data = rd;
    #1;
    g = -1;
    if (!alm && !dr && m_count < MAX)
      for (int k = 1; k <= N; k++) begin
        int i = (m_last + k) % N;
        if (v[i] && g < 0) g = i;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    ok = rv && (m_count > 0) && (rtag[2:0] < N);
    if (rv && !ok) m_err = 1'b1;
    if (ok) begin
      rsp_t r;
      r.vld = '0; r.vld[rtag[2:0]] = 1'b1; r.data = rd;
      rsp_q.push_back(r);
    end
    if (g >= 0) begin
      tx_t t;
      t.addr  = req_addr[g*42 +: 42];
      t.mdata = {m_seq[12:0], 3'(g)};
      tx_q.push_back(t);
      inflight.push_back(t.mdata);
      m_seq  = (m_seq + 1) % 8192;
      m_last = g;
    end
    m_count = m_count + ((g >= 0) ? 1 : 0) - (ok ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '1; c0_rsp_valid = 1'b0; drain = 1'b0; c0_alm_full = 1'b0;
    m_count = 0; m_last = N - 1; m_seq = 0; m_err = 1'b0;
    tx_q.delete(); rsp_q.delete(); inflight.delete();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_valid", c0_tx_valid, 0);
    chk("rst_tx_addr", c0_tx_addr, 0);
    chk("rst_tx_mdata", c0_tx_mdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err_unexpected, 0);
    @(negedge clk);
    chk("rst_req_ready_hold", req_ready, 0);
    req_valid = '0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; c0_alm_full = 1'b0; drain = 1'b0;
    c0_rsp_valid = 1'b0; c0_rsp_mdata = '0; c0_rsp_data = '0;
    m_count = 0; m_last = N - 1; m_seq = 0; m_err = 1'b0; obs_rsp = 0;
    do_reset();

    // Single read with fixed address and data
    use_fix = 1'b1;
    step(4'b0001, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("single_tx_valid", c0_tx_valid, 1);
    chk("single_tx_addr", c0_tx_addr, 42'h100);
    chk("single_tx_mdata", c0_tx_mdata, 16'h0000);
    step(4'b0000, 0, 0, 1, 0);
    @(posedge clk); #2;
    chk("single_rsp_valid", rsp_valid, 4'b0001);
    chk("single_rsp_data", rsp_data, 512'hAB);
    chk("single_idle", idle, 1);
    use_fix = 1'b0;

    // Fairness with prompt responses
    do_reset();
    obs_mdata.delete();
    repeat (6) step(4'hF, 0, 0, 1, 0);
    repeat (4) step(4'h0, 0, 0, 1, 0);
    chk("fair_count", obs_mdata.size(), 6);
    for (int i = 0; i < 6 && i < obs_mdata.size(); i++) chk("fair_mdata", obs_mdata[i], fair_exp[i]);

    // Credit limit
    do_reset();
    obs_mdata.delete();
    repeat (12) step(4'hF, 0, 0, 0, 0);
    step(4'h0, 0, 0, 0, 0);
    chk("credit_grants", obs_mdata.size(), MAX);
    step(4'hF, 0, 0, 1, 0);
    chk("credit_block", req_ready, 0);
    step(4'hF, 0, 0, 0, 0);
    chk("credit_regrant", |req_ready, 1);
    repeat (12) step(4'h0, 0, 0, 1, 0);

    // Backpressure, then drain with reads outstanding
    do_reset();
    obs_mdata.delete();
    repeat (5) step(4'hF, 1, 0, 0, 0);
    chk("almfull_grants", obs_mdata.size(), 0);
    repeat (3) step(4'hF, 0, 0, 0, 0);
    obs_rsp = 0;
    repeat (6) step(4'hF, 0, 1, 1, 0);
    step(4'h0, 0, 1, 0, 0);
    chk("drain_grants", obs_mdata.size(), 3);
    chk("drain_rsps", obs_rsp, 3);
    chk("drain_idle", idle, 1);

    // Unexpected response, then reset with reads outstanding
    do_reset();
    step(4'h0, 0, 0, 2, 16'h0000);
    @(posedge clk); #2;
    chk("unexp_rsp_valid", rsp_valid, 0);
    chk("unexp_err", err_unexpected, 1);
    do_reset();
    step(4'b0010, 0, 0, 0, 0);
    step(4'b0100, 0, 0, 0, 0);
    saved = inflight;
    step(4'h0, 0, 0, 0, 0);
    do_reset();
    step(4'h0, 0, 0, 2, saved[0]);
    step(4'h0, 0, 0, 2, saved[1]);
    @(posedge clk); #2;
    chk("late_rsp_valid", rsp_valid, 0);
    chk("late_err", err_unexpected, 1);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(99);
      if ($urandom_range(999) == 0) do_reset();
      else step(N'($urandom), ($urandom_range(99) < 15), ($urandom_range(99) < 10),
                (r < 45) ? 3 : (r < 48) ? 2 : 0,
                {13'($urandom), 3'($urandom_range(7, N))});
    end
    repeat (20) step(4'h0, 0, 0, 1, 0);
    step(4'h0, 0, 0, 0, 0);
    chk("end_tx_q_empty", tx_q.size(), 0);
    chk("end_rsp_q_empty", rsp_q.size(), 0);
    chk("end_idle", idle, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
